// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame controller: frame FSM states,
// frame-format constants and bit/byte timing helpers.
package uart_pkg;

  localparam logic [7:0]  SYNC_DEFAULT  = 8'hA5;
  localparam int unsigned MAX_LEN       = 14;
  localparam int unsigned BITS_PER_BYTE = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK
  } frame_state_t;

  // One byte time on the line, in system clock cycles (start + 8 data + stop).
  function automatic int unsigned byte_time_cycles(input int unsigned clk_freq,
                                                   input int unsigned bps);
    return BITS_PER_BYTE * (clk_freq / bps);
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts cycles while run is high and clear is low,
// and emits a registered one-cycle expire pulse once LIMIT cycles have elapsed.
module uart_gap_timer #(
  parameter int unsigned LIMIT = 300
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int unsigned CW   = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;
  logic          r_expire;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt    <= '0;
      r_expire <= 1'b0;
    end else begin
      r_expire <= 1'b0;
      if (clear || !run) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_cnt    <= '0;
        r_expire <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign expire = r_expire;

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame parser for SYNC/LEN/payload/CHK frames arriving from a byte UART,
// with a single-entry valid/ready output register and error pulses.
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned UART_BPS  = 9600,
  parameter int unsigned GAP_BYTES = 3,
  parameter logic [7:0]  SYNC      = SYNC_DEFAULT
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         rx_done,
  input  logic [7:0]   rx_byte,
  output logic         pkt_valid,
  input  logic         pkt_ready,
  output logic [3:0]   pkt_len,
  output logic [111:0] pkt_data,
  output logic         err_chk,
  output logic         err_timeout,
  output logic         err_len,
  output logic [7:0]   drop_cnt
);

  localparam int unsigned GAP_LIMIT = GAP_BYTES * byte_time_cycles(CLK_FREQ, UART_BPS);

  frame_state_t r_state;
  frame_state_t w_state_nxt;

  logic [3:0]   r_len;
  logic [7:0]   r_sum;
  logic [3:0]   r_idx;
  logic [111:0] r_buf;

  logic         r_pkt_valid;
  logic [3:0]   r_pkt_len;
  logic [111:0] r_pkt_data;
  logic         r_err_chk;
  logic         r_err_timeout;
  logic         r_err_len;
  logic [7:0]   r_drop_cnt;

  logic         w_expire;
  logic         w_timer_run;
  logic         w_len_ok;
  logic [7:0]   w_chk_exp;
  logic         w_chk_ok;
  logic         w_commit;
  logic         w_err_chk;
  logic         w_err_timeout;
  logic         w_err_len;
  logic         w_handshake;

  assign w_timer_run = (r_state != ST_IDLE);

  uart_gap_timer #(
    .LIMIT (GAP_LIMIT)
  ) u_gap_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (rx_done),
    .run       (w_timer_run),
    .expire    (w_expire)
  );

  assign w_len_ok  = (rx_byte != 8'd0) && (rx_byte <= 8'(MAX_LEN));
  assign w_chk_exp = r_sum + {4'h0, r_len};
  assign w_chk_ok  = (rx_byte == w_chk_exp);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A received byte takes priority over a coincident gap expiry.
  always_comb begin
    w_state_nxt   = r_state;
    w_commit      = 1'b0;
    w_err_chk     = 1'b0;
    w_err_timeout = 1'b0;
    w_err_len     = 1'b0;
    if (rx_done) begin
      unique case (r_state)
        ST_IDLE: begin
          if (rx_byte == SYNC) w_state_nxt = ST_LEN;
        end
        ST_LEN: begin
          if (w_len_ok) begin
            w_state_nxt = ST_PAYLOAD;
          end else begin
            w_err_len   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_PAYLOAD: begin
          if (r_idx == (r_len - 4'd1)) w_state_nxt = ST_CHECK;
        end
        ST_CHECK: begin
          if (w_chk_ok) w_commit  = 1'b1;
          else          w_err_chk = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (w_expire && (r_state != ST_IDLE)) begin
      w_err_timeout = 1'b1;
      w_state_nxt   = ST_IDLE;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_len <= '0;
      r_sum <= '0;
      r_idx <= '0;
      r_buf <= '0;
    end else if (rx_done) begin
      if (r_state == ST_LEN && w_len_ok) begin
        r_len <= rx_byte[3:0];
        r_sum <= '0;
        r_idx <= '0;
        r_buf <= '0;
      end else if (r_state == ST_PAYLOAD) begin
        r_buf[{r_idx, 3'b000} +: 8] <= rx_byte;
        r_sum <= r_sum + rx_byte;
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  assign w_handshake = r_pkt_valid && pkt_ready;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pkt_valid <= 1'b0;
      r_pkt_len   <= '0;
      r_pkt_data  <= '0;
      r_drop_cnt  <= '0;
    end else if (w_commit) begin
      if (!r_pkt_valid || pkt_ready) begin
        r_pkt_valid <= 1'b1;
        r_pkt_len   <= r_len;
        r_pkt_data  <= r_buf;
      end else if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (w_handshake) begin
      r_pkt_valid <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_err_chk     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_len     <= 1'b0;
    end else begin
      r_err_chk     <= w_err_chk;
      r_err_timeout <= w_err_timeout;
      r_err_len     <= w_err_len;
    end
  end

  assign pkt_valid   = r_pkt_valid;
  assign pkt_len     = r_pkt_len;
  assign pkt_data    = r_pkt_data;
  assign err_chk     = r_err_chk;
  assign err_timeout = r_err_timeout;
  assign err_len     = r_err_len;
  assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed and randomized bench for uart_frame_ctrl; expected packets and
// error counts come from a frame-level model built from the frame rules.
module tb_uart_frame_ctrl;

  localparam int unsigned CLK_FREQ  = 1000;
  localparam int unsigned UART_BPS  = 100;
  localparam int unsigned GAP_BYTES = 3;
  localparam int unsigned GAP       = GAP_BYTES * 10 * (CLK_FREQ / UART_BPS);
  localparam logic [7:0]  SYNC_B    = 8'hA5;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic         rx_done = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic         pkt_ready = 1'b0;
  logic         pkt_valid;
  logic [3:0]   pkt_len;
  logic [111:0] pkt_data;
  logic         err_chk;
  logic         err_timeout;
  logic         err_len;
  logic [7:0]   drop_cnt;

  always #5 sys_clk = ~sys_clk;

  uart_frame_ctrl #(
    .CLK_FREQ  (CLK_FREQ),
    .UART_BPS  (UART_BPS),
    .GAP_BYTES (GAP_BYTES),
    .SYNC      (SYNC_B)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .rx_done     (rx_done),
    .rx_byte     (rx_byte),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_len     (pkt_len),
    .pkt_data    (pkt_data),
    .err_chk     (err_chk),
    .err_timeout (err_timeout),
    .err_len     (err_len),
    .drop_cnt    (drop_cnt)
  );

  int n_checks = 0;
  int n_err    = 0;

  int n_chk_p   = 0;
  int n_to_p    = 0;
  int n_len_p   = 0;
  int n_multi   = 0;
  int n_vcycles = 0;
  logic [3:0]   got_len[$];
  logic [111:0] got_data[$];
  logic [3:0]   exp_len[$];
  logic [111:0] exp_data[$];

  logic [7:0] pay[14];
  logic [7:0] txq[$];

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (err_chk)     n_chk_p++;
      if (err_timeout) n_to_p++;
      if (err_len)     n_len_p++;
      if ((int'(err_chk) + int'(err_timeout) + int'(err_len)) > 1) n_multi++;
      if (pkt_valid) n_vcycles++;
      if (pkt_valid && pkt_ready) begin
        got_len.push_back(pkt_len);
        got_data.push_back(pkt_data);
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [111:0] pack_pay(input int len);
    logic [111:0] d = '0;
    for (int i = 0; i < len; i++) d = d | (112'(pay[i]) << (8 * i));
    return d;
  endfunction

  function automatic logic [7:0] chk_of(input int len);
    int s = len;
    for (int i = 0; i < len; i++) s = s + int'(pay[i]);
    return 8'(s % 256);
  endfunction

  task automatic make_frame(input int len, input bit bad);
    logic [7:0] c = chk_of(len);
    if (bad) c = c ^ 8'(1 + $urandom_range(0, 254));
    txq = {};
    txq.push_back(SYNC_B);
    txq.push_back(8'(len));
    for (int i = 0; i < len; i++) txq.push_back(pay[i]);
    txq.push_back(c);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge sys_clk); #1;
    rx_byte = b;
    rx_done = 1'b1;
    @(posedge sys_clk); #1;
    rx_done = 1'b0;
    rx_byte = 8'($urandom);
    repeat (gap) @(posedge sys_clk);
  endtask

  task automatic send_q(input int gap);
    foreach (txq[i]) send_byte(txq[i], gap);
  endtask

  task automatic settle();
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic check_last_pkt(input string tag, input int len, input logic [111:0] data);
    if (got_len.size() > 0) begin
      check({tag, "_len"},  128'(got_len[got_len.size()-1]),   128'(len));
      check({tag, "_data"}, 128'(got_data[got_data.size()-1]), 128'(data));
    end else begin
      check({tag, "_present"}, 128'(0), 128'(1));
    end
  endtask

  int   base_pkts, base_v, base_chk, base_len, base_to, k;
  bit   seen;
  logic [111:0] held;

  initial begin
    // reset values
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_valid",  128'(pkt_valid),   128'(0));
    check("rst_len",    128'(pkt_len),     128'(0));
    check("rst_data",   128'(pkt_data),    128'(0));
    check("rst_drop",   128'(drop_cnt),    128'(0));
    check("rst_errs",   128'({err_chk, err_timeout, err_len}), 128'(0));
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;

    // basic good frame, one-cycle commit latency
    pkt_ready = 1'b1;
    base_v = n_vcycles; base_pkts = got_len.size();
    txq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_q(0);
    @(negedge sys_clk);
    check("good_latency_valid", 128'(pkt_valid), 128'(1));
    settle();
    check("good_pkt_count", 128'(got_len.size() - base_pkts), 128'(1));
    check("good_valid_cycles", 128'(n_vcycles - base_v), 128'(1));
    check_last_pkt("good", 3, 112'h332211);

    // checksum error then recovery
    base_chk = n_chk_p; base_pkts = got_len.size();
    txq = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    send_q(0);
    settle();
    check("chkerr_pulse", 128'(n_chk_p - base_chk), 128'(1));
    check("chkerr_no_pkt", 128'(got_len.size() - base_pkts), 128'(0));
    txq = {8'hA5, 8'h01, 8'h42, 8'h43};
    send_q(0);
    settle();
    check_last_pkt("after_chkerr", 1, 112'h42);

    // illegal LEN, then junk + SYNC-led frame
    base_len = n_len_p; base_pkts = got_len.size();
    txq = {8'hA5, 8'h0F};
    send_q(0);
    settle();
    check("lenerr_pulse", 128'(n_len_p - base_len), 128'(1));
    txq = {8'h05, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_q(0);
    settle();
    check("after_lenerr_count", 128'(got_len.size() - base_pkts), 128'(1));
    check_last_pkt("after_lenerr", 1, 112'h7E);

    // inter-byte timeout
    base_to = n_to_p; base_pkts = got_len.size();
    txq = {8'hA5, 8'h02, 8'hAA};
    send_q(0);
    k = 0; seen = 1'b0;
    while (!seen && k < int'(GAP) + 20) begin
      @(negedge sys_clk);
      k++;
      if (err_timeout) seen = 1'b1;
    end
    check("timeout_seen", 128'(seen), 128'(1));
    check("timeout_latency_window", 128'((k >= int'(GAP)) && (k <= int'(GAP) + 3)), 128'(1));
    settle();
    check("timeout_count", 128'(n_to_p - base_to), 128'(1));
    check("timeout_no_pkt", 128'(got_len.size() - base_pkts), 128'(0));

    // gaps just under the limit must not time out
    base_to = n_to_p;
    pay[0] = 8'h01; pay[1] = 8'h02;
    make_frame(2, 1'b0);
    send_q(int'(GAP) - 10);
    settle();
    check("slow_no_timeout", 128'(n_to_p - base_to), 128'(0));
    check_last_pkt("slow", 2, pack_pay(2));

    // back-pressure: hold, drop, simultaneous handshake+commit
    pkt_ready = 1'b0;
    pay[0] = 8'hC1; pay[1] = 8'hC2;
    make_frame(2, 1'b0);
    send_q(0);
    settle();
    held = pack_pay(2);
    check("bp_first_valid", 128'(pkt_valid), 128'(1));
    check("bp_first_data", 128'(pkt_data), 128'(held));
    for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
    make_frame(3, 1'b0);
    send_q(1);
    settle();
    check("bp_drop_one", 128'(drop_cnt), 128'(1));
    check("bp_held_len", 128'(pkt_len), 128'(2));
    check("bp_held_data", 128'(pkt_data), 128'(held));
    for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
    make_frame(4, 1'b0);
    for (int i = 0; i < txq.size() - 1; i++) send_byte(txq[i], 0);
    @(posedge sys_clk); #1;
    rx_byte = txq[txq.size()-1];
    rx_done = 1'b1;
    pkt_ready = 1'b1;
    @(posedge sys_clk); #1;
    rx_done = 1'b0;
    pkt_ready = 1'b0;
    @(negedge sys_clk);
    check("bp_swap_valid", 128'(pkt_valid), 128'(1));
    check("bp_swap_len", 128'(pkt_len), 128'(4));
    check("bp_swap_data", 128'(pkt_data), 128'(pack_pay(4)));
    check("bp_swap_no_drop", 128'(drop_cnt), 128'(1));
    held = pack_pay(4);

    // drop counter saturation
    for (int f = 0; f < 260; f++) begin
      pay[0] = 8'($urandom);
      make_frame(1, 1'b0);
      send_q(0);
    end
    settle();
    check("drop_saturate", 128'(drop_cnt), 128'(255));
    check("drop_held_data", 128'(pkt_data), 128'(held));

    // reset mid-payload
    pkt_ready = 1'b1;
    base_chk = n_chk_p; base_len = n_len_p; base_to = n_to_p;
    txq = {8'hA5, 8'h05, 8'h01, 8'h02};
    send_q(0);
    #3 sys_rst_n = 1'b0;
    #1;
    check("midrst_outputs",
          128'({pkt_valid, pkt_len, err_chk, err_timeout, err_len, drop_cnt}), 128'(0));
    check("midrst_data", 128'(pkt_data), 128'(0));
    repeat (2) @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    settle();
    check("midrst_no_err", 128'((n_chk_p - base_chk) + (n_len_p - base_len) + (n_to_p - base_to)), 128'(0));
    for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
    make_frame(5, 1'b0);
    send_q(0);
    settle();
    check_last_pkt("midrst_after", 5, pack_pay(5));

    // randomized frames against the frame model
    got_len = {}; got_data = {}; exp_len = {}; exp_data = {};
    base_chk = n_chk_p; base_len = n_len_p; base_to = n_to_p;
    begin
      int e_chk = 0, e_len = 0, kind, len;
      logic [7:0] junk;
      for (int f = 0; f < 40; f++) begin
        if ($urandom_range(0, 3) == 0) begin
          junk = 8'($urandom);
          if (junk == SYNC_B) junk = 8'h00;
          send_byte(junk, 0);
        end
        kind = $urandom_range(0, 9);
        len  = $urandom_range(1, 14);
        for (int i = 0; i < 14; i++) pay[i] = 8'($urandom);
        if ($urandom_range(0, 2) == 0) pay[0] = SYNC_B;
        if (kind == 0) begin
          txq = {SYNC_B, ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(15, 255))};
          e_len++;
        end else if (kind == 1) begin
          make_frame(len, 1'b1);
          e_chk++;
        end else begin
          make_frame(len, 1'b0);
          exp_len.push_back(4'(len));
          exp_data.push_back(pack_pay(len));
        end
        send_q($urandom_range(0, 3));
        repeat (3) @(posedge sys_clk);
      end
      settle();
      check("rand_chk_errs", 128'(n_chk_p - base_chk), 128'(e_chk));
      check("rand_len_errs", 128'(n_len_p - base_len), 128'(e_len));
      check("rand_no_timeout", 128'(n_to_p - base_to), 128'(0));
      check("rand_pkt_count", 128'(got_len.size()), 128'(exp_len.size()));
      for (int i = 0; i < exp_len.size() && i < got_len.size(); i++) begin
        check($sformatf("rand_len_%0d", i),  128'(got_len[i]),  128'(exp_len[i]));
        check($sformatf("rand_data_%0d", i), 128'(got_data[i]), 128'(exp_data[i]));
      end
    end
    check("single_error_per_cycle", 128'(n_multi), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
